squeeze_piso: RTL and testbench

// - Parallel-in/serial-out squeeze unit; counterpart of the rate-block loader on the output side.
// - Captures the RATE-bit rate portion of the permutation state in one cycle and emits it as DATA_W-bit words.
// - Uses a valid/ready handshake for output words.
// - Counts the requested output length across blocks. Pulses perm_req for each extra permutation; pulses done at the end.

---
 rtl/squeeze_piso.sv | 152 +++++++++++++++
 tb/tb_squeeze_piso.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_piso.sv
// Parallel-in/serial-out squeeze unit: captures one rate block and emits it
// MSB word first over a valid/ready port, requesting extra permutations as needed.
module squeeze_piso #(
    parameter int DATA_W = 64,
    parameter int RATE   = 1344,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hash_init,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [RATE-1:0]   state_in,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              perm_req,
    output logic              busy,
    output logic              done
);

    localparam int WORDS = RATE / DATA_W;
    localparam int WC_W  = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [RATE-1:0]   shift_q,     shift_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [WC_W-1:0]   word_cnt_q,  word_cnt_d;
    logic              blk_ready_q, blk_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              perm_req_q,  perm_req_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        perm_req_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != {CNT_W{1'b0}}) begin
                        remaining_d = num_words;
                        state_d     = WAIT_BLK;
                    end else begin
                        state_d     = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BLK: begin
                if (blk_valid && blk_ready_q) begin
                    shift_d    = state_in;
                    word_cnt_d = WC_W'(WORDS);
                    state_d    = SHIFT;
                end else begin
                    state_d = WAIT_BLK;
                end
            end
            SHIFT: begin
                if (out_valid_q && out_ready) begin
                    shift_d     = {shift_q[RATE-DATA_W-1:0], {DATA_W{1'b0}}};
                    remaining_d = remaining_q - CNT_W'(1);
                    word_cnt_d  = word_cnt_q - WC_W'(1);
                    // Finishing the request wins over exhausting the block
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (word_cnt_q == WC_W'(1)) begin
                        perm_req_d = 1'b1;
                        state_d    = WAIT_BLK;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        blk_ready_d = (state_d == WAIT_BLK);
        out_valid_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);

        if (hash_init) begin
            state_d     = IDLE;
            shift_d     = {RATE{1'b0}};
            remaining_d = {CNT_W{1'b0}};
            word_cnt_d  = {WC_W{1'b0}};
            blk_ready_d = 1'b0;
            out_valid_d = 1'b0;
            perm_req_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= {RATE{1'b0}};
            remaining_q <= {CNT_W{1'b0}};
            word_cnt_q  <= {WC_W{1'b0}};
            blk_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            perm_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            blk_ready_q <= blk_ready_d;
            out_valid_q <= out_valid_d;
            perm_req_q  <= perm_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out  = shift_q[RATE-1 -: DATA_W];
    assign blk_ready = blk_ready_q;
    assign out_valid = out_valid_q;
    assign perm_req  = perm_req_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_squeeze_piso.sv
// Directed bench for squeeze_piso: one task per scenario with inline checks
// against hand-computed word values and handshake timing.
module tb_squeeze_piso;

    localparam int DATA_W = 64;
    localparam int RATE   = 1344;
    localparam int CNT_W  = 16;
    localparam int WORDS  = RATE / DATA_W;

    logic              clk;
    logic              rst_n;
    logic              hash_init;
    logic              start;
    logic [CNT_W-1:0]  num_words;
    logic [RATE-1:0]   state_in;
    logic              blk_valid;
    logic              blk_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic              perm_req;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    logic [RATE-1:0] blk_a;
    logic [RATE-1:0] blk_b;

    squeeze_piso #(.DATA_W(DATA_W), .RATE(RATE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hash_init (hash_init),
        .start     (start),
        .num_words (num_words),
        .state_in  (state_in),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .perm_req  (perm_req),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k (k=0 at the MSB end) holds base + k + 1
    function automatic logic [RATE-1:0] mk_block(input logic [DATA_W-1:0] base);
        logic [RATE-1:0] b;
        b = {RATE{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            b[RATE-1-k*DATA_W -: DATA_W] = base + DATA_W'(k + 1);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hash_init = 1'b0; start = 1'b0; num_words = 16'd0;
        state_in = {RATE{1'b0}}; blk_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        checks++;
        if ({blk_ready, out_valid, perm_req, busy, done} !== 5'b00000 || data_out !== 64'd0)
            begin errors++; $display("FAIL reset_outputs: got ctl=%b data=%h expected ctl=00000 data=0",
                {blk_ready, out_valid, perm_req, busy, done}, data_out); end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_single_block();
        int perm_seen;
        perm_seen = 0;
        state_in = blk_a; blk_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; num_words = 16'd21;
        step();
        start = 1'b0;
        checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL single_wait: got blk_ready=%b busy=%b out_valid=%b expected 1 1 0", blk_ready, busy, out_valid); end
        step();
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'(i + 1))
                begin errors++; $display("FAIL single_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data_out, 64'(i + 1)); end
            if (perm_req === 1'b1) perm_seen++;
            step();
        end
        if (perm_req === 1'b1) perm_seen++;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL single_done: got done=%b out_valid=%b expected 1 0", done, out_valid); end
        checks++;
        if (perm_seen !== 0) begin errors++; $display("FAIL single_noperm: got %0d perm_req cycles expected 0", perm_seen); end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL single_idle: got done=%b busy=%b expected 0 0", done, busy); end
        blk_valid = 1'b0;
    endtask

    task automatic test_multi_block();
        int hs;
        hs = 0;
        state_in = blk_a; blk_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; num_words = 16'd25;
        step();
        start = 1'b0;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'(i + 1))
                begin errors++; $display("FAIL multi_a_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data_out, 64'(i + 1)); end
            if (out_valid === 1'b1) hs++;
            step();
        end
        checks++;
        if (perm_req !== 1'b1 || blk_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL multi_perm: got perm_req=%b blk_ready=%b out_valid=%b expected 1 1 0", perm_req, blk_ready, out_valid); end
        state_in = blk_b; blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        checks++;
        if (perm_req !== 1'b0) begin errors++; $display("FAIL multi_perm_pulse: got perm_req=%b expected 0", perm_req); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'h0000_0000_0000_B000 + 64'(i + 1))
                begin errors++; $display("FAIL multi_b_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data_out, 64'h0000_0000_0000_B000 + 64'(i + 1)); end
            if (out_valid === 1'b1) hs++;
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL multi_done: got done=%b expected 1", done); end
        checks++;
        if (hs !== 25) begin errors++; $display("FAIL multi_handshakes: got %0d expected 25", hs); end
        step();
    endtask

    task automatic test_backpressure();
        state_in = blk_a; blk_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; num_words = 16'd3;
        step();
        start = 1'b0;
        step();
        blk_valid = 1'b0;
        checks++;
        if (data_out !== 64'd1) begin errors++; $display("FAIL bp_w0: got %h expected 1", data_out); end
        step();
        checks++;
        if (data_out !== 64'd2) begin errors++; $display("FAIL bp_w1: got %h expected 2", data_out); end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'd2 || done !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h done=%b expected 1 2 0", i, out_valid, data_out, done); end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 64'd3)
            begin errors++; $display("FAIL bp_w2: got valid=%b data=%h expected 1 3", out_valid, data_out); end
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_done: got done=%b valid=%b expected 1 0", done, out_valid); end
        step();
    endtask

    task automatic test_zero_words();
        int stray;
        stray = 0;
        start = 1'b1; num_words = 16'd0; blk_valid = 1'b1;
        step();
        start = 1'b0;
        if (blk_ready === 1'b1 || out_valid === 1'b1) stray++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1 1", done, busy); end
        step();
        if (blk_ready === 1'b1 || out_valid === 1'b1) stray++;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL zero_idle: got done=%b busy=%b expected 0 0", done, busy); end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL zero_stray: got %0d cycles with blk_ready/out_valid expected 0", stray); end
        blk_valid = 1'b0;
    endtask

    task automatic test_hash_init();
        state_in = blk_a; blk_valid = 1'b1; out_ready = 1'b1;
        start = 1'b1; num_words = 16'd21;
        step();
        start = 1'b0;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (data_out !== 64'd10) begin errors++; $display("FAIL hinit_pre: got %h expected 10", data_out); end
        hash_init = 1'b1;
        step();
        hash_init = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 64'd0 || done !== 1'b0)
            begin errors++; $display("FAIL hinit_clear: got valid=%b busy=%b data=%h done=%b expected 0 0 0 0", out_valid, busy, data_out, done); end
        state_in = blk_b; blk_valid = 1'b1;
        start = 1'b1; num_words = 16'd3;
        step();
        start = 1'b0;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'h0000_0000_0000_B000 + 64'(i + 1))
                begin errors++; $display("FAIL hinit_word%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, data_out, 64'h0000_0000_0000_B000 + 64'(i + 1)); end
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL hinit_done: got done=%b expected 1", done); end
        step();
    endtask

    task automatic test_async_reset();
        blk_valid = 1'b0;
        start = 1'b1; num_words = 16'd5;
        step();
        start = 1'b0;
        checks++;
        if (blk_ready !== 1'b1) begin errors++; $display("FAIL arst_wait: got blk_ready=%b expected 1", blk_ready); end
        state_in = blk_a; blk_valid = 1'b1; rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({blk_ready, out_valid, perm_req, busy, done} !== 5'b00000 || data_out !== 64'd0)
                begin errors++; $display("FAIL arst_low%0d: got ctl=%b data=%h expected ctl=00000 data=0", i, {blk_ready, out_valid, perm_req, busy, done}, data_out); end
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({blk_ready, out_valid, busy} !== 3'b000 || data_out !== 64'd0)
                begin errors++; $display("FAIL arst_idle%0d: got ready/valid/busy=%b data=%h expected 000 data=0", i, {blk_ready, out_valid, busy}, data_out); end
        end
        blk_valid = 1'b0;
    endtask

    initial begin
        blk_a = mk_block(64'd0);
        blk_b = mk_block(64'h0000_0000_0000_B000);
        test_reset();
        test_single_block();
        test_multi_block();
        test_backpressure();
        test_zero_words();
        test_hash_init();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
